// File: rtl/rv32_w_fp_writeback_arbiter.sv
// Merges in-order FP pipeline writebacks with queued long-latency FP results into
// one registered register-file write per cycle, and tracks pending long-latency writes.
module rv32_w_fp_writeback_arbiter #(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_data_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  output logic [31:0] busy_o,
  output logic        stall_o,
  output logic        write_enable_4_o,
  output logic [4:0]  write_address_4_o,
  output logic [31:0] write_data_4_o
);

  localparam int AW = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lu_entry_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_PIPE, SEL_FIFO} sel_e;

  lu_entry_t     mem [LU_DEPTH];
  lu_entry_t     head;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve_cnt, starve_next;
  logic [31:0]   busy_next;
  logic          fifo_empty, push, pop;
  sel_e          sel;

  assign fifo_empty = (count == '0);
  assign lu_ready_o = !rst_i && (count < (AW+1)'(LU_DEPTH));
  assign push       = lu_valid_i && lu_ready_o;
  assign head       = mem[rd_ptr];
  assign pop        = (sel == SEL_FIFO);

  // A starved FIFO head outranks the pipeline; otherwise the pipeline has priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = SEL_NONE;
    if (stall_o && !fifo_empty) sel = SEL_FIFO;
    else if (pipe_we_i)         sel = SEL_PIPE;
    else if (!fifo_empty)       sel = SEL_FIFO;
  end

  always_comb begin
    starve_next = '0;
    if (!fifo_empty && !pop)
      starve_next = (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
  end

  // Set is applied after clear so a same-cycle issue to the retiring rd keeps the bit.
  always_comb begin
    busy_next = busy_o;
    if (pop)           busy_next[head.rd]    = 1'b0;
    if (issue_valid_i) busy_next[issue_rd_i] = 1'b1;
  end

  // NOTE: the FIFO storage has no reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{rd: lu_rd_i, data: lu_data_i};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      stall_o    <= 1'b0;
      busy_o     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
      stall_o    <= (starve_next == CW'(STARVE_LIMIT));
      busy_o     <= busy_next;
    end
  end

  // Address and data hold their last values on idle cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_enable_4_o  <= 1'b0;
      write_address_4_o <= '0;
      write_data_4_o    <= '0;
    end else begin
      write_enable_4_o <= (sel != SEL_NONE);
      case (sel)
        SEL_PIPE: begin
          write_address_4_o <= pipe_rd_i;
          write_data_4_o    <= pipe_data_i;
        end
        SEL_FIFO: begin
          write_address_4_o <= head.rd;
          write_data_4_o    <= head.data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_w_fp_writeback_arbiter.sv
// Randomised and directed bench for the FP writeback arbiter; a queue-based reference
// model predicts each cycle and a monitor process compares the DUT against it.
module tb_rv32_w_fp_writeback_arbiter;

  localparam int LU_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pipe_we_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] busy_o;
  logic        stall_o;
  logic        write_enable_4_o;
  logic [4:0]  write_address_4_o;
  logic [31:0] write_data_4_o;

  rv32_w_fp_writeback_arbiter #(.LU_DEPTH(LU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .pipe_we_i         (pipe_we_i),
    .pipe_rd_i         (pipe_rd_i),
    .pipe_data_i       (pipe_data_i),
    .lu_valid_i        (lu_valid_i),
    .lu_ready_o        (lu_ready_o),
    .lu_rd_i           (lu_rd_i),
    .lu_data_i         (lu_data_i),
    .issue_valid_i     (issue_valid_i),
    .issue_rd_i        (issue_rd_i),
    .busy_o            (busy_o),
    .stall_o           (stall_o),
    .write_enable_4_o  (write_enable_4_o),
    .write_address_4_o (write_address_4_o),
    .write_data_4_o    (write_data_4_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct packed {
    logic        we;
    logic [31:0] busy;
    logic        stall;
    logic        ready;
  } st_t;

  // Reference model state: FIFO as a queue, unserved-cycle count, busy bitmap.
  ent_t        m_fifo[$];
  int          m_unserved;
  bit          m_stall;
  logic [31:0] m_busy;

  ent_t wr_q[$];
  st_t  state_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_unserved = 0;
    m_stall    = 0;
    m_busy     = '0;
    wr_q.delete();
    state_q.delete();
  endtask

  // Drive one cycle of inputs, predict its outcome, and return at the following negedge.
  task automatic cyc(input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic iv, input logic [4:0] ird);
    ent_t w;
    ent_t n;
    st_t  s;
    bit   nonempty, popped, accepted;
    pipe_we_i     = pwe;
    pipe_rd_i     = prd;
    pipe_data_i   = pdat;
    lu_valid_i    = lv;
    lu_rd_i       = lrd;
    lu_data_i     = ldat;
    issue_valid_i = iv;
    issue_rd_i    = ird;

    nonempty = (m_fifo.size() > 0);
    accepted = lv && (m_fifo.size() < LU_DEPTH);
    popped   = 0;
    s        = '0;
    if (nonempty && (m_stall || !pwe)) begin
      w = m_fifo.pop_front();
      popped = 1;
      m_busy[w.rd] = 1'b0;
      s.we = 1'b1;
      wr_q.push_back(w);
    end else if (pwe) begin
      w.rd   = prd;
      w.data = pdat;
      s.we   = 1'b1;
      wr_q.push_back(w);
    end
    if (iv) m_busy[ird] = 1'b1;
    if (accepted) begin
      n.rd   = lrd;
      n.data = ldat;
      m_fifo.push_back(n);
    end
    if (nonempty && !popped) m_unserved = (m_unserved < STARVE_LIMIT) ? m_unserved + 1 : STARVE_LIMIT;
    else                     m_unserved = 0;
    m_stall = (m_unserved == STARVE_LIMIT);
    s.busy  = m_busy;
    s.stall = m_stall;
    s.ready = (m_fifo.size() < LU_DEPTH);
    state_q.push_back(s);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Monitor: compares each predicted cycle and every presented write.
  always begin
    st_t  e;
    ent_t w;
    @(posedge clk_i);
    #1;
    if (state_q.size() > 0) begin
      e = state_q.pop_front();
      check("mon_we",    32'(write_enable_4_o), 32'(e.we));
      check("mon_busy",  busy_o,                e.busy);
      check("mon_stall", 32'(stall_o),          32'(e.stall));
      check("mon_ready", 32'(lu_ready_o),       32'(e.ready));
      if (write_enable_4_o) begin
        if (wr_q.size() == 0) begin
          check("mon_unexpected_write", 32'(write_enable_4_o), 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("mon_addr", 32'(write_address_4_o), 32'(w.rd));
          check("mon_data", write_data_4_o,         w.data);
        end
      end
    end
  end

  initial begin
    int n;
    rst_i = 1'b1;
    pipe_we_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
    lu_valid_i = 0; lu_rd_i = 0; lu_data_i = 0;
    issue_valid_i = 0; issue_rd_i = 0;
    model_clear();
    #1;
    check("rst_we",    32'(write_enable_4_o),  32'd0);
    check("rst_addr",  32'(write_address_4_o), 32'd0);
    check("rst_data",  write_data_4_o,         32'd0);
    check("rst_busy",  busy_o,                 32'd0);
    check("rst_stall", 32'(stall_o),           32'd0);
    check("rst_ready", 32'(lu_ready_o),        32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_release_ready", 32'(lu_ready_o), 32'd1);

    // Pipe only
    cyc(1'b1, 5'd3, 32'h3F80_0000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("pipe_f3_we",   32'(write_enable_4_o),  32'd1);
    check("pipe_f3_addr", 32'(write_address_4_o), 32'd3);
    cyc(1'b1, 5'd4, 32'h4000_0000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("pipe_f4_addr", 32'(write_address_4_o), 32'd4);
    check("pipe_f4_data", write_data_4_o,         32'h4000_0000);
    idle(1);
    check("pipe_idle_we",   32'(write_enable_4_o),  32'd0);
    check("pipe_idle_hold", 32'(write_address_4_o), 32'd4);

    // Long-latency path
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    check("ll_busy_set", 32'(busy_o[5]), 32'd1);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h4049_0FDB, 1'b0, 5'd0);
    check("ll_no_bypass", 32'(write_enable_4_o), 32'd0);
    idle(1);
    check("ll_we",         32'(write_enable_4_o),  32'd1);
    check("ll_addr",       32'(write_address_4_o), 32'd5);
    check("ll_data",       write_data_4_o,         32'h4049_0FDB);
    check("ll_busy_clear", 32'(busy_o[5]),         32'd0);
    idle(2);

    // Contention with the pipe held high
    cyc(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd7, 32'h7777_0007, 1'b0, 5'd0);
    cyc(1'b1, 5'd1, 32'h1111_0002, 1'b1, 5'd8, 32'h8888_0008, 1'b0, 5'd0);
    n = 0;
    while (!stall_o && n < 10) begin
      cyc(1'b1, 5'd1, 32'h1111_0100 + n, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      n++;
    end
    check("cont_wait_first", n, 3);
    cyc(1'b1, 5'd1, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("cont_f7_addr",  32'(write_address_4_o), 32'd7);
    check("cont_f7_data",  write_data_4_o,         32'h7777_0007);
    check("cont_f7_stall", 32'(stall_o),           32'd0);
    n = 0;
    while (!stall_o && n < 10) begin
      cyc(1'b1, 5'd1, 32'h1111_0200 + n, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      n++;
    end
    check("cont_wait_second", n, STARVE_LIMIT);
    cyc(1'b1, 5'd1, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("cont_f8_addr", 32'(write_address_4_o), 32'd8);
    idle(2);

    // Full FIFO
    cyc(1'b1, 5'd1, 32'h2222_0001, 1'b1, 5'd10, 32'hAAAA_000A, 1'b0, 5'd0);
    cyc(1'b1, 5'd1, 32'h2222_0002, 1'b1, 5'd11, 32'hBBBB_000B, 1'b0, 5'd0);
    check("full_ready_low", 32'(lu_ready_o), 32'd0);
    cyc(1'b1, 5'd1, 32'h2222_0003, 1'b1, 5'd12, 32'hCCCC_000C, 1'b0, 5'd0);
    check("full_held_off", 32'(lu_ready_o), 32'd0);
    idle(1);
    check("full_pop_addr",  32'(write_address_4_o), 32'd10);
    check("full_ready_up",  32'(lu_ready_o),        32'd1);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hDDDD_000D, 1'b0, 5'd0);
    check("full_pushpop_addr",  32'(write_address_4_o), 32'd11);
    check("full_pushpop_ready", 32'(lu_ready_o),        32'd1);
    idle(1);
    check("full_last_addr", 32'(write_address_4_o), 32'd13);
    idle(1);
    check("full_drained", 32'(write_enable_4_o), 32'd0);

    // Scoreboard collision
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0001, 1'b0, 5'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    check("coll_addr",      32'(write_address_4_o), 32'd9);
    check("coll_busy_kept", 32'(busy_o[9]),         32'd1);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0002, 1'b0, 5'd0);
    idle(1);
    check("coll_busy_clear", 32'(busy_o[9]), 32'd0);
    idle(1);

    // Reset mid-operation
    cyc(1'b1, 5'd1, 32'h3333_0001, 1'b1, 5'd2, 32'h0202_0202, 1'b1, 5'd2);
    cyc(1'b1, 5'd1, 32'h3333_0002, 1'b1, 5'd5, 32'h0505_0505, 1'b1, 5'd5);
    check("mrst_busy_before", busy_o, 32'h0000_0024);
    pipe_we_i = 0; lu_valid_i = 0; issue_valid_i = 0;
    rst_i = 1'b1;
    #1;
    model_clear();
    check("mrst_we",    32'(write_enable_4_o),  32'd0);
    check("mrst_addr",  32'(write_address_4_o), 32'd0);
    check("mrst_data",  write_data_4_o,         32'd0);
    check("mrst_busy",  busy_o,                 32'd0);
    check("mrst_stall", 32'(stall_o),           32'd0);
    check("mrst_ready", 32'(lu_ready_o),        32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("mrst_release_ready", 32'(lu_ready_o), 32'd1);
    idle(1);
    check("mrst_fifo_empty", 32'(write_enable_4_o), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom), $urandom,
          ($urandom_range(0, 3) == 0), 5'($urandom));
    end
    idle(6);
    check("end_wr_q_empty",    wr_q.size(),    32'd0);
    check("end_state_q_empty", state_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_w_fp_writeback_arbiter.md
# rv32_w_fp_writeback_arbiter

Writer-side front end for the FP register file's single write port (port 4). It merges results from the in-order FP pipeline writeback stage with out-of-order results from long-latency FP units (FDIV/FSQRT) into one registered write per cycle. It also keeps a per-register pending-write scoreboard that decode uses to stall on RAW/WAW hazards against in-flight long-latency ops. The register file samples the write at the negedge, so every output changes only at the posedge and is stable when sampled.

## Interface
- LU_DEPTH, 2: long-latency result FIFO depth; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive unserved cycles with the FIFO non-empty before `stall_o` asserts; ≥1.
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- pipe_we_i  in  1  pipeline writeback valid; no backpressure.
- pipe_rd_i  in  5  pipeline destination f-register.
- pipe_data_i  in  32  pipeline result.
- lu_valid_i  in  1  long-latency result valid.
- lu_ready_o  out  1  FIFO can accept; `LU_COUNT < LU_DEPTH` and not in reset.
- lu_rd_i  in  5  long-latency destination.
- lu_data_i  in  32  long-latency result.
- issue_valid_i  in  1  a long-latency op issues this cycle.
- issue_rd_i  in  5  its destination.
- busy_o  out  32  scoreboard; bit n set means fn has a pending long-latency write.
- stall_o  out  1  registered request for the pipeline to present no write this cycle.
- write_enable_4_o  out  1  registered write enable to the register file.
- write_address_4_o  out  5  registered write address.
- write_data_4_o  out  32  registered write data.

## Operation
- **FIFO push:** `lu_valid_i && lu_ready_o` at a posedge. Entries are {rd, data}. Source order is preserved.
- **Selection each cycle (registered at the posedge):**
  - If `stall_o`=1 and the FIFO is non-empty: pop the head and write it. A concurrent `pipe_we_i` is a protocol violation; the pipe write is dropped.
  - Else if `pipe_we_i`: write the pipe result.
  - Else if the FIFO is non-empty: pop the head and write it.
  - Else: `write_enable_4_o`=0. Address and data hold their last values.
- **Push and pop in the same cycle:** count is unchanged. A push is never accepted while full, because ready is low.
- **Starve counter:**
  - Increments when the FIFO is non-empty and not popped. Saturates at STARVE_LIMIT.
  - Clears on any pop, or when the FIFO is empty.
  - `stall_o` is registered and equals (next counter == STARVE_LIMIT). It drops the cycle after the forced pop unless the condition re-arises.
- **Scoreboard:**
  - `busy[issue_rd_i]` is set on `issue_valid_i`.
  - `busy[rd]` is cleared when a FIFO entry for rd is written to the output registers.
  - Set and clear of the same rd in the same cycle: set wins.
  - Pipe writes never touch busy.
  - Issuing to an already-busy rd leaves the bit set. Decode must not do this.
- All 32 f-registers are real; f0 is not special.

## Timing
- **Reset (async assert):**
  - `write_enable_4_o`=0, `write_address_4_o`=0, `write_data_4_o`=0.
  - `busy_o`=0, `stall_o`=0, FIFO empty, starve counter 0.
  - `lu_ready_o`=0 while `rst_i` is high and 1 after release.
- **Reset mid-operation:** FIFO contents and pending busy bits are discarded.
- **Pipe path:** `pipe_we_i` at cycle N produces `write_enable_4_o`=1 in cycle N+1, and the register file writes at the N+1 negedge.
- **Long-latency path:** push at edge E; earliest `write_enable_4_o`=1 in the cycle after edge E+1. There is no FIFO bypass.
- **Busy clear timing:** the busy bit clears at the same edge that raises `write_enable_4_o` for that entry. Decode may read the register after that negedge.
- **`lu_ready_o`:** combinational from the registered count only; no dependence on `lu_valid_i`.
- **Worst-case throughput:** one write per cycle.

## Test plan
- **Reset:** assert `rst_i` mid-stream with 2 FIFO entries and busy=0x0000_0024 → all outputs 0 immediately, `lu_ready_o`=0. After release, `lu_ready_o`=1 and the FIFO is empty.
- **Pipe only:** pipe writes f3=0x3F80_0000, then f4=0x4000_0000 on consecutive cycles → `write_enable_4_o` high two cycles, address 3 then 4, data matching, one cycle late.
- **Long-latency path:**
  - Stimulus: issue rd=5, giving busy[5]=1; push {5, 0x4049_0FDB} while pipe is idle.
  - Required: write to f5 two cycles after the push; busy[5] clears at the same edge.
- **Contention:**
  - Stimulus: FIFO holds f7, f8; `pipe_we_i` is held high continuously (STARVE_LIMIT=4).
  - Required: pipe writes win for 4 cycles; then `stall_o`=1; next cycle f7 is written and the pipe write is not written; the counter re-arms for f8.
- **Full FIFO:** push 2 entries with the pipe busy → `lu_ready_o`=0 and a third `lu_valid_i` is held off. After one pop, ready=1; the push and a later pop in the same cycle keep count=1.
- **Scoreboard collision:** pop an entry for f9 in the same cycle as a new issue to f9 → busy[9] stays 1. A later pop of that f9 entry clears it.
